// File: rtl/pipe_stall_ctrl_pkg.sv
// pipe_stall_ctrl_pkg: shared stall-vector constants and multi-cycle FSM state encodings
package pipe_stall_ctrl_pkg;
    localparam logic RST_ENABLE = 1'b1;
    localparam int STALL_PC  = 0;
    localparam int STALL_IF  = 1;
    localparam int STALL_ID  = 2;
    localparam int STALL_EXB = 3;
    localparam int STALL_MEM = 4;
    localparam int STALL_WB  = 5;
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_IDV  = 6'b000111;
    localparam logic [5:0] STALL_EXV  = 6'b001111;
    typedef enum logic [1:0] {
        MC_IDLE = 2'b00,
        MC_BUSY = 2'b01,
        MC_DONE = 2'b10
    } mc_state_e;
endpackage

// File: rtl/pipe_stall_ctrl_mc_op_counter.sv
// mc_op_counter: multi-cycle EX op FSM with down-counter; holds EX for N+1 cycles then pulses done
module mc_op_counter
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             ex_mc_start,
    input  logic [CNT_W-1:0] ex_mc_cycles,
    output logic             ex_hold,
    output logic             ex_mc_done,
    output logic             mc_busy
);
    mc_state_e        state;
    logic [CNT_W-1:0] cnt;
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state <= MC_IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                MC_IDLE: if (ex_mc_start && !flush) begin
                    cnt   <= (ex_mc_cycles == '0) ? CNT_W'(1) : ex_mc_cycles;
                    state <= MC_BUSY;
                end
                MC_BUSY: if (flush) state <= MC_IDLE;
                    else if (cnt == CNT_W'(1)) state <= MC_DONE;
                    else cnt <= cnt - CNT_W'(1);
                default: state <= MC_IDLE;
            endcase
        end
    end
    // outputs forced low while reset is asserted, even before the first reset edge
    assign ex_hold    = (rst != RST_ENABLE) && ((state == MC_IDLE && ex_mc_start) || state == MC_BUSY);
    assign ex_mc_done = (rst != RST_ENABLE) && (state == MC_DONE);
    assign mc_busy    = (rst != RST_ENABLE) && (state != MC_IDLE);
endmodule

// File: rtl/pipe_stall_ctrl.sv
// pipe_stall_ctrl: stall vector priority mux (flush > EX multi-cycle > ID hazard).
// Optional perf counters enabled by PIPE_STALL_CTRL_PERF_EN.
module pipe_stall_ctrl
    import pipe_stall_ctrl_pkg::*;
#(
    parameter int STALL_W = 6,
    parameter int CNT_W   = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               stallreq_from_id,
    input  logic               ex_mc_start,
    input  logic [CNT_W-1:0]   ex_mc_cycles,
    output logic [STALL_W-1:0] stall,
    output logic               ex_mc_done,
    output logic               mc_busy
`ifdef PIPE_STALL_CTRL_PERF_EN
    ,
    input  logic               perf_clr,
    output logic [31:0]        perf_stall_ex,
    output logic [31:0]        perf_stall_id
`endif
);
    logic ex_hold;
    mc_op_counter #(.CNT_W(CNT_W)) u_mc (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .ex_mc_start  (ex_mc_start),
        .ex_mc_cycles (ex_mc_cycles),
        .ex_hold      (ex_hold),
        .ex_mc_done   (ex_mc_done),
        .mc_busy      (mc_busy)
    );
    always_comb begin
        stall = (rst == RST_ENABLE || flush) ? STALL_W'(STALL_NONE) :
                ex_hold                      ? STALL_W'(STALL_EXV)  :
                stallreq_from_id             ? STALL_W'(STALL_IDV)  : STALL_W'(STALL_NONE);
    end
`ifdef PIPE_STALL_CTRL_PERF_EN
    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE || perf_clr) begin
            perf_stall_ex <= '0;
            perf_stall_id <= '0;
        end else begin
            if (stall == STALL_W'(STALL_EXV) && perf_stall_ex != '1) perf_stall_ex <= perf_stall_ex + 32'd1;
            if (stall == STALL_W'(STALL_IDV) && perf_stall_id != '1) perf_stall_id <= perf_stall_id + 32'd1;
        end
    end
`endif
endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// tb_pipe_stall_ctrl: directed self-checking bench for pipe_stall_ctrl
module tb_pipe_stall_ctrl;
    logic       clk = 1'b0;
    logic       rst, flush, stallreq_from_id, ex_mc_start;
    logic [5:0] ex_mc_cycles;
    logic [5:0] stall;
    logic       ex_mc_done, mc_busy;
    int         passed = 0;
    int         total = 0;
`ifdef PIPE_STALL_CTRL_PERF_EN
    logic        perf_clr = 1'b0;
    logic [31:0] perf_stall_ex, perf_stall_id;
`endif

    pipe_stall_ctrl dut (
        .clk              (clk),
        .rst              (rst),
        .flush            (flush),
        .stallreq_from_id (stallreq_from_id),
        .ex_mc_start      (ex_mc_start),
        .ex_mc_cycles     (ex_mc_cycles),
        .stall            (stall),
        .ex_mc_done       (ex_mc_done),
        .mc_busy          (mc_busy)
`ifdef PIPE_STALL_CTRL_PERF_EN
        ,
        .perf_clr         (perf_clr),
        .perf_stall_ex    (perf_stall_ex),
        .perf_stall_id    (perf_stall_id)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passed++;
        else $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // advance one clock, then let combinational outputs settle after inputs change
    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [5:0] s, input logic d, input logic b);
        #1;
        chk({tag, "_stall"}, 32'(stall), 32'(s));
        chk({tag, "_done"}, 32'(ex_mc_done), 32'(d));
        chk({tag, "_busy"}, 32'(mc_busy), 32'(b));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stallreq_from_id = 1'b1; ex_mc_start = 1'b1; ex_mc_cycles = 6'd3;
        tick;
        chk_out("rst0", 6'b000000, 1'b0, 1'b0);
        tick;
        chk_out("rst1", 6'b000000, 1'b0, 1'b0);
        // release reset: op with N=3 starts at T
        rst = 1'b0;
        chk_out("n3_T", 6'b001111, 1'b0, 1'b0);
        stallreq_from_id = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            tick;
            chk_out($sformatf("n3_T%0d", k), 6'b001111, 1'b0, 1'b1);
        end
        tick;
        chk_out("n3_T4", 6'b000000, 1'b1, 1'b1);
        tick;
        ex_mc_start = 1'b0;
        chk_out("n3_T5", 6'b000000, 1'b0, 1'b0);
        // N=0 behaves as N=1
        tick;
        ex_mc_start = 1'b1; ex_mc_cycles = 6'd0;
        chk_out("n0_T", 6'b001111, 1'b0, 1'b0);
        tick;
        chk_out("n0_T1", 6'b001111, 1'b0, 1'b1);
        tick;
        chk_out("n0_T2", 6'b000000, 1'b1, 1'b1);
        tick;
        ex_mc_start = 1'b0;
        chk_out("n0_T3", 6'b000000, 1'b0, 1'b0);
        // ID request during an N=2 op: EX pattern wins until DONE
        tick;
        ex_mc_start = 1'b1; ex_mc_cycles = 6'd2; stallreq_from_id = 1'b1;
        chk_out("id_T", 6'b001111, 1'b0, 1'b0);
        tick;
        chk_out("id_T1", 6'b001111, 1'b0, 1'b1);
        tick;
        chk_out("id_T2", 6'b001111, 1'b0, 1'b1);
        tick;
        chk_out("id_T3", 6'b000111, 1'b1, 1'b1);
        tick;
        ex_mc_start = 1'b0;
        chk_out("id_T4", 6'b000111, 1'b0, 1'b0);
        // flush with start in IDLE: nothing starts
        tick;
        stallreq_from_id = 1'b0; ex_mc_start = 1'b1; ex_mc_cycles = 6'd5; flush = 1'b1;
        chk_out("fli", 6'b000000, 1'b0, 1'b0);
        tick;
        flush = 1'b0; ex_mc_start = 1'b0;
        chk_out("fli_n", 6'b000000, 1'b0, 1'b0);
        // flush at T+2 of an N=5 op, then a restart with full count
        tick;
        ex_mc_start = 1'b1;
        chk_out("fl_T", 6'b001111, 1'b0, 1'b0);
        tick;
        chk_out("fl_T1", 6'b001111, 1'b0, 1'b1);
        tick;
        flush = 1'b1;
        chk_out("fl_T2", 6'b000000, 1'b0, 1'b1);
        tick;
        flush = 1'b0;
        chk_out("fl_T3", 6'b001111, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            tick;
            chk_out($sformatf("fl_R%0d", k), 6'b001111, 1'b0, 1'b1);
        end
        tick;
        chk_out("fl_R6", 6'b000000, 1'b1, 1'b1);
        tick;
        ex_mc_start = 1'b0;
        chk_out("fl_R7", 6'b000000, 1'b0, 1'b0);
        // reset mid-op: back to IDLE, no done pulse
        tick;
        ex_mc_start = 1'b1; ex_mc_cycles = 6'd4;
        tick;
        chk_out("rm_busy", 6'b001111, 1'b0, 1'b1);
        rst = 1'b1;
        chk_out("rm_rst", 6'b000000, 1'b0, 1'b0);
        tick;
        rst = 1'b0; ex_mc_start = 1'b0;
        chk_out("rm_post", 6'b000000, 1'b0, 1'b0);
        tick;
        chk_out("rm_post2", 6'b000000, 1'b0, 1'b0);
`ifdef PIPE_STALL_CTRL_PERF_EN
        perf_clr = 1'b1;
        tick;
        perf_clr = 1'b0; ex_mc_start = 1'b1; ex_mc_cycles = 6'd4;
        for (int k = 0; k < 5; k++) tick;
        ex_mc_start = 1'b0;
        chk_out("pf_done", 6'b000000, 1'b1, 1'b1);
        tick;
        stallreq_from_id = 1'b1;
        for (int k = 0; k < 3; k++) tick;
        stallreq_from_id = 1'b0;
        chk("pf_ex", perf_stall_ex, 32'd5);
        chk("pf_id", perf_stall_id, 32'd3);
        perf_clr = 1'b1;
        tick;
        perf_clr = 1'b0;
        chk("pf_clr_ex", perf_stall_ex, 32'd0);
        chk("pf_clr_id", perf_stall_id, 32'd0);
        force dut.perf_stall_id = 32'hFFFFFFFF;
        #1;
        release dut.perf_stall_id;
        stallreq_from_id = 1'b1;
        tick;
        stallreq_from_id = 1'b0;
        chk("pf_sat", perf_stall_id, 32'hFFFFFFFF);
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
